// File: rtl/alu_result_stage.sv
// alu_result_stage
//   EX-stage output register behind the ALU result mux. Each accepted beat
//   gets its N/Z status computed here and is presented one cycle later to the
//   EX/MEM boundary under a valid/ready handshake. The stage also owns the
//   architectural NZCV register, which is written only by legal flag-setting
//   operations at accept time, independent of downstream stalls.
//
//   Build option: ALU_RESULT_STAGE_SKID_EN
//     defined   - two-entry buffer (main + skid); in_ready comes from a register
//     undefined - single entry; in_ready = out_ready | ~out_valid
//
//   Ports
//     clk, reset_n                 clock, async active-low reset
//     in_valid / in_ready          upstream handshake
//     in_result[WIDTH]             ALU mux output
//     in_cntrl[3]                  op code (001/111 illegal)
//     in_carry, in_overflow        adder status (used only for add/sub)
//     in_set_flags                 op writes NZCV
//     out_valid / out_ready        downstream handshake
//     out_result, out_zero         registered result and its zero status
//     out_illegal                  beat carried an illegal op code
//     flags[4]                     architectural {N,Z,C,V}
module alu_result_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [2:0]       in_cntrl,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_illegal,
   output logic [3:0]       flags
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             illegal;
   } beat_t;

   logic       w_accept, w_emit;
   logic       w_illegal, w_cv_en, w_n, w_z;
   beat_t      w_beat;
   logic [3:0] r_flags;
   logic       r_valid;
   beat_t      r_main;

   assign w_accept = in_valid & in_ready;
   assign w_emit   = r_valid & out_ready;

   always_comb begin
      w_illegal = (in_cntrl == 3'b001) || (in_cntrl == 3'b111);
      w_cv_en   = (in_cntrl == 3'b010) || (in_cntrl == 3'b011);
      w_n       = in_result[WIDTH-1];
      // Wide NOR reduction sits before the register so it shares the ALU cycle.
      w_z       = ~|in_result;
      w_beat.result  = w_illegal ? '0 : in_result;
      // Zero status describes the payload actually presented, so an illegal
      // beat (result forced to 0) reports zero.
      w_beat.zero    = w_illegal | w_z;
      w_beat.illegal = w_illegal;
   end

   // Architectural flags update at accept, never at emit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_flags <= 4'b0000;
      else if (w_accept && in_set_flags && !w_illegal)
         r_flags <= {w_n, w_z, in_carry & w_cv_en, in_overflow & w_cv_en};
   end

`ifdef ALU_RESULT_STAGE_SKID_EN
   logic  r_skid_valid;
   logic  r_in_ready;
   beat_t r_skid;

   assign in_ready = r_in_ready;

   // in_ready is low exactly while the skid entry is occupied, so no accept
   // can coincide with a full skid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid      <= 1'b0;
         r_main       <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
         r_in_ready   <= 1'b1;
      end else if (r_skid_valid) begin
         if (w_emit) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end
      end else if (w_accept) begin
         if (!r_valid || w_emit) begin
            r_main  <= w_beat;
            r_valid <= 1'b1;
         end else begin
            r_skid       <= w_beat;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
         end
      end else if (w_emit) begin
         r_valid <= 1'b0;
      end
   end
`else
   assign in_ready = out_ready | ~r_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_main  <= '0;
      end else if (w_accept) begin
         r_main  <= w_beat;
         r_valid <= 1'b1;
      end else if (w_emit) begin
         r_valid <= 1'b0;
      end
   end
`endif

   assign out_valid   = r_valid;
   assign out_result  = r_main.result;
   assign out_zero    = r_main.zero;
   assign out_illegal = r_main.illegal;
   assign flags       = r_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_result;
   logic [2:0]  in_cntrl;
   logic        in_carry;
   logic        in_overflow;
   logic        in_set_flags;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_zero;
   logic        out_illegal;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        i;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   logic bp_done;

   alu_result_stage #(.WIDTH(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_cntrl(in_cntrl),
      .in_carry(in_carry), .in_overflow(in_overflow), .in_set_flags(in_set_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
      .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Monitor: every beat emitted downstream is matched against the scoreboard.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got result=%h zero=%b illegal=%b", out_result, out_zero, out_illegal);
         end else begin
            m_e = q.pop_front();
            if (out_result !== m_e.r || out_zero !== m_e.z || out_illegal !== m_e.i) begin
               errors++;
               $display("FAIL beat got result=%h zero=%b illegal=%b expected result=%h zero=%b illegal=%b",
                        out_result, out_zero, out_illegal, m_e.r, m_e.z, m_e.i);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Present one beat, wait (bounded) for in_ready, record the expected
   // output beat, and drop in_valid just after the accepting edge.
   task automatic send(input logic [63:0] res, input logic [2:0] c, input logic cy,
                       input logic ov, input logic sf,
                       input logic [63:0] er, input logic ez, input logic ei);
      int n = 0;
      exp_t e;
      in_valid = 1'b1; in_result = res; in_cntrl = c;
      in_carry = cy; in_overflow = ov; in_set_flags = sf;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout got in_ready=0 expected 1 for result=%h", res);
      end else begin
         e.r = er; e.z = ez; e.i = ei;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(q.size()), 64'd0);
   endtask

   initial begin
      logic skid;
`ifdef ALU_RESULT_STAGE_SKID_EN
      skid = 1'b1;
`else
      skid = 1'b0;
`endif
      reset_n = 1'b0; in_valid = 1'b0; in_result = '0; in_cntrl = 3'b000;
      in_carry = 1'b0; in_overflow = 1'b0; in_set_flags = 1'b0; out_ready = 1'b1;
      bp_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_zero", 64'(out_zero), 64'd0);
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Zero result from add with carry: N=0 Z=1 C=1 V=0.
      send(64'd0, 3'b010, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
      chk("flags_add_zero", 64'(flags), 64'h6);
      // Negative sub result.
      send(64'hFFFF_FFFF_FFFF_F68E, 3'b011, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_F68E, 1'b0, 1'b0);
      chk("flags_sub_neg", 64'(flags), 64'h8);
      // Non-flag-setting xor leaves flags alone.
      send(64'h1234, 3'b110, 1'b1, 1'b1, 1'b0, 64'h1234, 1'b0, 1'b0);
      chk("flags_xor_hold", 64'(flags), 64'h8);
      // Illegal 111: result forced 0, flags untouched.
      send(64'd10, 3'b111, 1'b1, 1'b1, 1'b1, 64'd0, 1'b1, 1'b1);
      chk("flags_illegal111", 64'(flags), 64'h8);
      // Add with signed overflow: V only.
      send(64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      chk("flags_add_ovf", 64'(flags), 64'h1);
      // AND: carry/overflow inputs forced to 0 in the flags.
      send(64'h8000_0000_0000_0000, 3'b100, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      chk("flags_and_cv_forced", 64'(flags), 64'h8);
      // Illegal 001 also never writes flags.
      send(64'd0, 3'b001, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b1);
      chk("flags_illegal001", 64'(flags), 64'h8);
      // OR with pass-through.
      send(64'h00F0, 3'b101, 1'b0, 1'b0, 1'b1, 64'h00F0, 1'b0, 1'b0);
      chk("flags_or", 64'(flags), 64'h0);
      drain();

      // Back-pressure: three beats against a stalled output.
      @(posedge clk); #1;
      out_ready = 1'b0;
      fork
         begin
            send(64'd100, 3'b000, 1'b0, 1'b0, 1'b0, 64'd100, 1'b0, 1'b0);
            send(64'd64, 3'b000, 1'b0, 1'b0, 1'b0, 64'd64, 1'b0, 1'b0);
            send(64'd10000, 3'b000, 1'b0, 1'b0, 1'b0, 64'd10000, 1'b0, 1'b0);
            bp_done = 1'b1;
         end
      join_none
      @(negedge clk);
      @(negedge clk);
      chk("bp_in_ready_after_first", 64'(in_ready), 64'(skid));
      repeat (2) @(negedge clk);
      chk("bp_in_ready_stalled", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_hold", out_result, 64'd100);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int n = 0; n < 100 && !bp_done; n++) @(negedge clk);
      chk("bp_done", 64'(bp_done), 64'd1);
      drain();

      // Reset mid-stall: buffered beats must vanish.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_result = 64'd5; in_cntrl = 3'b010;
      in_carry = 1'b1; in_overflow = 1'b0; in_set_flags = 1'b1;
      @(posedge clk); #1;
      in_result = 64'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rs_flags_before", 64'(flags), 64'h2);
      reset_n = 1'b0;
      #1;
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_flags", 64'(flags), 64'd0);
      chk("rs_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("rs_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      send(64'd42, 3'b011, 1'b1, 1'b0, 1'b1, 64'd42, 1'b0, 1'b0);
      chk("post_rst_flags", 64'(flags), 64'h2);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
